// File: rtl/mc_pkg.sv
// mc_pkg: shared sequencer state type, opcode constants and register select codes.
package mc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_RETIRE
    } ifetch_state_t;

    localparam logic [3:0] OP_ALU_FIRST = 4'b1001;

    localparam logic [5:0] REG_G0 = 6'd0;
    localparam logic [5:0] REG_P0 = 6'd1;
    localparam logic [5:0] REG_G1 = 6'd2;
    localparam logic [5:0] REG_G2 = 6'd3;
    localparam logic [5:0] REG_G3 = 6'd4;
    localparam logic [5:0] REG_P1 = 6'd5;

    function automatic logic [3:0] opcode_of(input logic [15:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/ifetch_watchdog.sv
// ifetch_watchdog: counts EXEC cycles and flags expiry on the TIMEOUT-th cycle.
module ifetch_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic exec_i,
    output logic expire_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= exec_i ? cnt_q + 8'd1 : 8'd0;
    end

    assign expire_o = exec_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: PC owner and fetch/exec/retire sequencer for the execute FSMs.
// Optional EXEC watchdog is enabled by defining IFETCH_WATCHDOG_EN.
module ifetch_seq
    import mc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic              PC_inc,
    input  logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       fullBitNum,
    output logic              IF_active,
    output logic              exec_timeout
);

    ifetch_state_t     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q;
    logic              if_active_q, mem_req_q, timeout_q;
    logic              exec, expire, wd_fire;

    assign exec = state_q == S_EXEC;

`ifdef IFETCH_WATCHDOG_EN
    ifetch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .exec_i   (exec),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // A real done in the expiry cycle wins; the timeout only covers a missing done.
    assign wd_fire = expire && !done;

    always_comb begin
        state_d = state_q == S_IDLE  ? S_FETCH :
                  state_q == S_FETCH ? (mem_ready ? S_EXEC : S_FETCH) :
                  state_q == S_EXEC  ? ((done || wd_fire) ? S_RETIRE : S_EXEC) :
                                       S_FETCH;
        pc_d    = pc_q + ADDR_W'(exec && (PC_inc || wd_fire));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            if_active_q <= 1'b1;
            mem_req_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if (state_q == S_FETCH && mem_ready) ir_q <= mem_rdata;
            if_active_q <= state_d != S_EXEC;
            mem_req_q   <= state_d == S_FETCH;
            if (wd_fire) timeout_q <= 1'b1;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = pc_q;
    assign fullBitNum   = ir_q;
    assign IF_active    = if_active_q;
    assign exec_timeout = timeout_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// tb_ifetch_seq: directed checks of fetch, stall, PC rules, wrap, watchdog and async reset.
module tb_ifetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready, PC_inc, done;
    logic        mem_req, IF_active, exec_timeout;
    logic [7:0]  mem_addr;
    logic [15:0] fullBitNum;
    int          checks = 0;
    int          failures = 0;

    ifetch_seq #(.ADDR_W(8), .RESET_PC(8'd0), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .PC_inc       (PC_inc),
        .done         (done),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .fullBitNum   (fullBitNum),
        .IF_active    (IF_active),
        .exec_timeout (exec_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int remaining, n;
        rst = 1'b1; mem_rdata = 16'h9042; mem_ready = 1'b1; PC_inc = 1'b0; done = 1'b0;
        tick; tick;
        chk("rst_ifa", IF_active, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ir", fullBitNum, 0);
        chk("rst_to", exec_timeout, 0);
        rst = 1'b0;
        tick;
        chk("fetch0_req", mem_req, 1);
        chk("fetch0_addr", mem_addr, 0);
        chk("fetch0_ifa", IF_active, 1);
        tick;
        chk("exec0_ir", fullBitNum, 16'h9042);
        chk("exec0_ifa", IF_active, 0);
        chk("exec0_req", mem_req, 0);
        PC_inc = 1'b1;
        tick;
        PC_inc = 1'b0;
        chk("exec0_pc", mem_addr, 1);
        for (int i = 0; i < 8; i++) tick;
        chk("exec0_hold_ifa", IF_active, 0);
        chk("exec0_hold_ir", fullBitNum, 16'h9042);
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("retire_ifa", IF_active, 1);
        chk("retire_req", mem_req, 0);
        chk("retire_addr", mem_addr, 1);
        mem_ready = 1'b0; mem_rdata = 16'h1234; PC_inc = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            done = 1'b1;
            chk("stall_req", mem_req, 1);
            chk("stall_ifa", IF_active, 1);
            chk("stall_ir", fullBitNum, 16'h9042);
            chk("stall_addr", mem_addr, 1);
            tick;
        end
        done = 1'b0; PC_inc = 1'b0;
        chk("stall4_req", mem_req, 1);
        chk("stall4_ifa", IF_active, 1);
        mem_ready = 1'b1;
        tick;
        chk("exec1_ir", fullBitNum, 16'h1234);
        chk("exec1_ifa", IF_active, 0);
        remaining = 254;
        while (remaining > 0) begin
            n = remaining > 10 ? 10 : remaining;
            PC_inc = 1'b1;
            for (int i = 0; i < n - 1; i++) tick;
            done = 1'b1;
            tick;
            PC_inc = 1'b0; done = 1'b0;
            remaining -= n;
            tick;
            tick;
        end
        chk("pre_wrap_addr", mem_addr, 8'hFF);
        chk("pre_wrap_ifa", IF_active, 0);
        PC_inc = 1'b1; done = 1'b1;
        tick;
        PC_inc = 1'b0; done = 1'b0;
        chk("wrap_addr", mem_addr, 0);
        chk("wrap_ifa", IF_active, 1);
        mem_rdata = 16'h0ABC;
        tick;
        chk("wrap_fetch_req", mem_req, 1);
        chk("wrap_fetch_addr", mem_addr, 0);
        tick;
        chk("wd_exec_ir", fullBitNum, 16'h0ABC);
`ifdef IFETCH_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick;
        chk("wd_pre_ifa", IF_active, 0);
        chk("wd_pre_to", exec_timeout, 0);
        tick;
        chk("wd_to", exec_timeout, 1);
        chk("wd_addr", mem_addr, 1);
        chk("wd_ifa", IF_active, 1);
        tick;
        chk("wd_fetch_req", mem_req, 1);
        chk("wd_fetch_addr", mem_addr, 1);
        tick;
        chk("wd_sticky", exec_timeout, 1);
`else
        for (int i = 0; i < 40; i++) tick;
        chk("nowd_ifa", IF_active, 0);
        chk("nowd_req", mem_req, 0);
        chk("nowd_addr", mem_addr, 0);
        chk("nowd_to", exec_timeout, 0);
`endif
        chk("mid_exec_ifa", IF_active, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_ifa", IF_active, 1);
        chk("arst_req", mem_req, 0);
        chk("arst_ir", fullBitNum, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_to", exec_timeout, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
